video_timing_multimode: RTL

Parametrised raster timing generator that supersedes the fixed-mode video timing block. It sits between the pixel clock domain and the pixel sources (test pattern, compositor, pointer). It adds runtime mode selection applied only at frame boundaries, per-mode sync polarity, and a pixel clock-enable so it can run from the 2x PLL clock. It also adds single-cycle line/frame start strobes.

---
 rtl/video_timing_multimode_pkg.sv | 91 +++++++++
 rtl/video_timing_multimode_axis.sv | 73 +++++++
 rtl/video_timing_multimode.sv | 131 +++++++++++++
 3 files changed

// File: rtl/video_timing_multimode_pkg.sv
// video_timing_multimode_pkg
//   Shared raster mode table for the timing generator, compositor and
//   pattern generators. Holds the mode index constants, the per-mode
//   horizontal/vertical act/fp/sync/bp segment lengths and sync polarity,
//   and decode helpers that map a mode index onto those fields.
//   No ports (package).
package video_timing_multimode_pkg;

  localparam int TIM_W = 16;

  localparam logic [1:0] MODE_720P    = 2'd0;
  localparam logic [1:0] MODE_SVGA    = 2'd1;
  localparam logic [1:0] MODE_VGA     = 2'd2;
  localparam logic [1:0] MODE_BRINGUP = 2'd3;

  typedef struct packed {
    logic [TIM_W-1:0] act;
    logic [TIM_W-1:0] fp;
    logic [TIM_W-1:0] sync;
    logic [TIM_W-1:0] bp;
  } axis_timing_t;

  // pol = 1: sync pulse drives high; pol = 0: sync pulse drives low.
  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    logic         h_pol;
    logic         v_pol;
  } mode_timing_t;

  typedef enum logic [2:0] {
    F_ACT,
    F_FP,
    F_SYNC,
    F_BP,
    F_TOTAL
  } axis_field_e;

  function automatic mode_timing_t mode_decode(input logic [1:0] m);
    mode_timing_t t;
    t.h_pol = 1'b1;
    t.v_pol = 1'b1;
    case (m)
      MODE_720P: begin
        t.h = '{act: 16'd1280, fp: 16'd110, sync: 16'd40,  bp: 16'd220};
        t.v = '{act: 16'd720,  fp: 16'd5,   sync: 16'd5,   bp: 16'd20};
      end
      MODE_SVGA: begin
        t.h = '{act: 16'd800,  fp: 16'd40,  sync: 16'd128, bp: 16'd88};
        t.v = '{act: 16'd600,  fp: 16'd1,   sync: 16'd4,   bp: 16'd23};
      end
      MODE_VGA: begin
        t.h = '{act: 16'd640,  fp: 16'd16,  sync: 16'd96,  bp: 16'd48};
        t.v = '{act: 16'd480,  fp: 16'd10,  sync: 16'd2,   bp: 16'd33};
        t.h_pol = 1'b0;
        t.v_pol = 1'b0;
      end
      default: begin
        // Tiny raster for simulation and bring-up.
        t.h = '{act: 16'd8,    fp: 16'd2,   sync: 16'd2,   bp: 16'd2};
        t.v = '{act: 16'd4,    fp: 16'd1,   sync: 16'd1,   bp: 16'd1};
      end
    endcase
    return t;
  endfunction

  function automatic logic [TIM_W-1:0] mode_field(input logic [1:0]  m,
                                                  input logic        vert,
                                                  input axis_field_e f);
    mode_timing_t     t;
    axis_timing_t     a;
    logic [TIM_W-1:0] r;
    t = mode_decode(m);
    a = vert ? t.v : t.h;
    case (f)
      F_ACT:   r = a.act;
      F_FP:    r = a.fp;
      F_SYNC:  r = a.sync;
      F_BP:    r = a.bp;
      default: r = a.act + a.fp + a.sync + a.bp;
    endcase
    return r;
  endfunction

  function automatic logic mode_pol(input logic [1:0] m, input logic vert);
    mode_timing_t t;
    t = mode_decode(m);
    return vert ? t.v_pol : t.h_pol;
  endfunction

endpackage

// File: rtl/video_timing_multimode_axis.sv
// video_timing_multimode_axis
//   One raster axis (horizontal or vertical): position counter that wraps at
//   a runtime total, plus active-area and sync-window decode of the position
//   it is about to take. Decoded outputs are registered so they line up with
//   the counter on the same edge.
// Ports:
//   clk, reset        clock, async active-high reset
//   ce, adv           counter steps when both are high (adv = carry in)
//   total             total of the mode governing the current frame
//   dec_act/fp/sync   segment lengths of the mode governing the next position
//   dec_pol           sync polarity of that mode
//   at_last           counter sits on total-1 (combinational carry out)
//   act_nxt           next position lies inside the active segment
//   pos               registered position shown downstream
//   sync_lvl          registered sync output level
//   start             one-cycle pulse: pos just wrapped to 0
module video_timing_multimode_axis #(
  parameter int              CW       = 16,
  parameter logic [CW-1:0]   RST_CNT  = '0,
  parameter logic            RST_SYNC = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          adv,
  input  logic [CW-1:0] total,
  input  logic [CW-1:0] dec_act,
  input  logic [CW-1:0] dec_fp,
  input  logic [CW-1:0] dec_sync,
  input  logic          dec_pol,
  output logic          at_last,
  output logic          act_nxt,
  output logic [CW-1:0] pos,
  output logic          sync_lvl,
  output logic          start
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] sync_lo;
  logic [CW-1:0] sync_hi;
  logic          step;
  logic          in_sync;

  assign step     = ce & adv;
  assign at_last  = (cnt == total - CW'(1));
  assign cnt_nxt  = !step ? cnt : (at_last ? '0 : cnt + CW'(1));
  assign sync_lo  = dec_act + dec_fp;
  assign sync_hi  = sync_lo + dec_sync;
  assign act_nxt  = (cnt_nxt < dec_act);
  assign in_sync  = (cnt_nxt >= sync_lo) && (cnt_nxt < sync_hi);

  // The internal counter resets to the last position so the first advance
  // is a wrap; the visible position output resets to 0 independently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= RST_CNT;
      pos      <= '0;
      sync_lvl <= RST_SYNC;
      start    <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (ce) begin
        pos      <= cnt_nxt;
        sync_lvl <= in_sync ? dec_pol : ~dec_pol;
        start    <= step & at_last;
      end else begin
        start    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/video_timing_multimode.sv
// video_timing_multimode
//   Multi-mode raster timing generator. Mode requests are taken only on the
//   cycle that advances out of the last pixel of a frame; everything else
//   follows the mode latched there. Runs from a 2x clock via ce.
// Ports:
//   clk          pixel-domain clock
//   reset        async active-high reset
//   ce           pixel advance enable; state holds while low
//   mode         requested mode, sampled at the frame boundary
//   hsync/vsync  sync outputs at per-mode polarity
//   visible      inside the active area
//   x, y         raw raster position (runs through blanking)
//   line_start   one-cycle pulse when x becomes 0
//   frame_start  one-cycle pulse when (x,y) becomes (0,0)
//   mode_active  mode governing the current frame
module video_timing_multimode
  import video_timing_multimode_pkg::*;
#(
  parameter int         COORD_W    = 16,
  parameter logic [1:0] RESET_MODE = 2'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic [1:0]         mode,
  output logic               hsync,
  output logic               vsync,
  output logic               visible,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic [1:0]         mode_active
);

  localparam logic [COORD_W-1:0] RST_H_LAST =
    COORD_W'(mode_field(RESET_MODE, 1'b0, F_TOTAL) - 16'd1);
  localparam logic [COORD_W-1:0] RST_V_LAST =
    COORD_W'(mode_field(RESET_MODE, 1'b1, F_TOTAL) - 16'd1);
  localparam logic RST_HSYNC = ~mode_pol(RESET_MODE, 1'b0);
  localparam logic RST_VSYNC = ~mode_pol(RESET_MODE, 1'b1);

  logic               h_last;
  logic               v_last;
  logic               frame_end;
  logic [1:0]         mode_nxt;
  logic               h_act_nxt;
  logic               v_act_nxt;
  logic [COORD_W-1:0] h_total;
  logic [COORD_W-1:0] v_total;
  logic [COORD_W-1:0] h_act_n;
  logic [COORD_W-1:0] h_fp_n;
  logic [COORD_W-1:0] h_sync_n;
  logic [COORD_W-1:0] v_act_n;
  logic [COORD_W-1:0] v_fp_n;
  logic [COORD_W-1:0] v_sync_n;
  logic               h_pol_n;
  logic               v_pol_n;

  // Wrap points follow the current frame's mode; window decode follows the
  // mode that will own the next position, so the first pixel of a new-mode
  // frame already decodes against the new timing.
  assign frame_end = ce & h_last & v_last;
  assign mode_nxt  = frame_end ? mode : mode_active;

  assign h_total  = COORD_W'(mode_field(mode_active, 1'b0, F_TOTAL));
  assign v_total  = COORD_W'(mode_field(mode_active, 1'b1, F_TOTAL));
  assign h_act_n  = COORD_W'(mode_field(mode_nxt, 1'b0, F_ACT));
  assign h_fp_n   = COORD_W'(mode_field(mode_nxt, 1'b0, F_FP));
  assign h_sync_n = COORD_W'(mode_field(mode_nxt, 1'b0, F_SYNC));
  assign v_act_n  = COORD_W'(mode_field(mode_nxt, 1'b1, F_ACT));
  assign v_fp_n   = COORD_W'(mode_field(mode_nxt, 1'b1, F_FP));
  assign v_sync_n = COORD_W'(mode_field(mode_nxt, 1'b1, F_SYNC));
  assign h_pol_n  = mode_pol(mode_nxt, 1'b0);
  assign v_pol_n  = mode_pol(mode_nxt, 1'b1);

  video_timing_multimode_axis #(
    .CW       (COORD_W),
    .RST_CNT  (RST_H_LAST),
    .RST_SYNC (RST_HSYNC)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .adv      (1'b1),
    .total    (h_total),
    .dec_act  (h_act_n),
    .dec_fp   (h_fp_n),
    .dec_sync (h_sync_n),
    .dec_pol  (h_pol_n),
    .at_last  (h_last),
    .act_nxt  (h_act_nxt),
    .pos      (x),
    .sync_lvl (hsync),
    .start    (line_start)
  );

  // The vertical axis carries in from the horizontal wrap; its own wrap
  // pulse therefore coincides exactly with the frame boundary.
  video_timing_multimode_axis #(
    .CW       (COORD_W),
    .RST_CNT  (RST_V_LAST),
    .RST_SYNC (RST_VSYNC)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .adv      (h_last),
    .total    (v_total),
    .dec_act  (v_act_n),
    .dec_fp   (v_fp_n),
    .dec_sync (v_sync_n),
    .dec_pol  (v_pol_n),
    .at_last  (v_last),
    .act_nxt  (v_act_nxt),
    .pos      (y),
    .sync_lvl (vsync),
    .start    (frame_start)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      visible     <= 1'b0;
      mode_active <= RESET_MODE;
    end else if (ce) begin
      visible     <= h_act_nxt & v_act_nxt;
      mode_active <= mode_nxt;
    end
  end

endmodule
